// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU (AND/OR/ADD/SLT with operand inversion).
// One 1-bit slice is reused LSB first; its carry is registered between bits.
// Optional feature macro: SLT_OVF_FIX_EN. When defined, SLT corrects its
// sign bit with signed overflow. When undefined, SLT uses the raw sum sign.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [3:0]       ctl_q;
    logic             carry_q;
    logic             cin_msb_q;

    logic             bits_done;
    logic             slice_sum, slice_carry;
    logic             is_arith;
    logic             fin_ovf, fin_set;
    logic [WIDTH-1:0] fin_result;

    // {sum, carry_next} of one slice; logic ops force the carry to 0
    function automatic logic [1:0] slice_fn(input logic ai, input logic bi,
                                            input logic ci, input logic [1:0] op);
        logic [1:0] r;
        r = 2'b00;
        case (op)
            2'b00:   r = {ai & bi, 1'b0};
            2'b01:   r = {ai | bi, 1'b0};
            default: r = {ai ^ bi ^ ci, (ai & bi) | (ai & ci) | (bi & ci)};
        endcase
        return r;
    endfunction

    assign bits_done = (cnt_q == CNT_W'(WIDTH));
    assign in_ready  = (state_q == IDLE);
    assign is_arith  = ctl_q[1];

    // Current bit slice; shifted operand registers present bit i at position 0
    always_comb begin
        {slice_sum, slice_carry} = slice_fn(a_q[0] ^ ctl_q[3], b_q[0] ^ ctl_q[2],
                                            carry_q, ctl_q[1:0]);
    end

    // Final result and flags once all bits are in; carry_q now holds carry out of MSB
    always_comb begin
        fin_ovf = is_arith ? (cin_msb_q ^ carry_q) : 1'b0;
`ifdef SLT_OVF_FIX_EN
        fin_set = sum_q[WIDTH-1] ^ fin_ovf;
`else
        fin_set = sum_q[WIDTH-1];
`endif
        fin_result = sum_q;
        if (ctl_q[1:0] == 2'b11) fin_result = {{(WIDTH-1){1'b0}}, fin_set};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (bits_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, serial evaluation and result holding
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            ctl_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        ctl_q   <= ALUctl;
                        cnt_q   <= '0;
                        carry_q <= ALUctl[2];
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    if (!bits_done) begin
                        sum_q   <= {slice_sum, sum_q[WIDTH-1:1]};
                        a_q     <= a_q >> 1;
                        b_q     <= b_q >> 1;
                        carry_q <= slice_carry;
                        if (cnt_q == CNT_W'(WIDTH - 1)) cin_msb_q <= carry_q;
                        cnt_q   <= cnt_q + 1'b1;
                    end else begin
                        result    <= fin_result;
                        zero      <= (fin_result == '0);
                        carry_out <= carry_q;
                        overflow  <= fin_ovf;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Testbench for serial_alu_seq: directed and random operations checked
// against an arithmetic reference model of the ALU operations.
module tb_serial_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   ALUctl;
    logic         zero, carry_out, overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUctl(ALUctl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow)
    );

    // Reference: whole-word arithmetic on the decoded operation
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [3:0] ctl, output logic [W-1:0] r,
                                  output logic z, output logic c, output logic v);
        logic [W-1:0] ai, bi;
        logic [W:0]   s;
        logic         set;
        ai = ctl[3] ? ~ma : ma;
        bi = ctl[2] ? ~mb : mb;
        s  = {1'b0, ai} + {1'b0, bi} + (W+1)'(ctl[2]);
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (ctl[1:0])
            2'b00: r = ai & bi;
            2'b01: r = ai | bi;
            2'b10: begin
                r = s[W-1:0];
                c = s[W];
                v = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
            end
            default: begin
                c = s[W];
                v = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
                set = s[W-1];
`ifdef SLT_OVF_FIX_EN
                set = set ^ v;
`endif
                r = {{(W-1){1'b0}}, set};
            end
        endcase
        z = (r == '0);
    endfunction

    // Present a request for the acceptance edge, then scramble the inputs
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] tc);
        a = ta; b = tb; ALUctl = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; ALUctl = 4'($urandom);
    endtask

    // Cycles from acceptance edge until out_valid, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if ({result, zero, carry_out, overflow} !== '0)
            $display("FAIL reset_outputs got %h %b%b%b want 0", result, zero, carry_out, overflow); else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4], tb[4], er[4];
        logic [3:0]   tc[4];
        logic         ez[4], ec[4], ev[4];
        int lat;
        ta[0] = 32'h0000_0005; tb[0] = 32'h0000_0003; tc[0] = 4'b0010; er[0] = 32'h8; ez[0] = 0; ec[0] = 0; ev[0] = 0;
        ta[1] = 32'h8000_0000; tb[1] = 32'h0000_0001; tc[1] = 4'b0110; er[1] = 32'h7FFF_FFFF; ez[1] = 0; ec[1] = 1; ev[1] = 1;
`ifdef SLT_OVF_FIX_EN
        er[2] = 32'h1; ez[2] = 0;
`else
        er[2] = 32'h0; ez[2] = 1;
`endif
        ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0001; tc[2] = 4'b0111; ec[2] = 1; ev[2] = 1;
        ta[3] = 32'hFFFF_0000; tb[3] = 32'h0FF0_0FF0; tc[3] = 4'b0000; er[3] = 32'h0FF0_0000; ez[3] = 0; ec[3] = 0; ev[3] = 0;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i], tc[i]);
            wait_done(lat);
            n_checks++; if (lat != W + 1) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, W + 1); else n_pass++;
            n_checks++; if (result !== er[i]) $display("FAIL dir%0d_result got %h want %h", i, result, er[i]); else n_pass++;
            n_checks++; if (zero !== ez[i]) $display("FAIL dir%0d_zero got %b want %b", i, zero, ez[i]); else n_pass++;
            n_checks++; if (carry_out !== ec[i]) $display("FAIL dir%0d_carry got %b want %b", i, carry_out, ec[i]); else n_pass++;
            n_checks++; if (overflow !== ev[i]) $display("FAIL dir%0d_overflow got %b want %b", i, overflow, ev[i]); else n_pass++;
            release_result();
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] r0;
        int lat;
        start_op(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100);
        wait_done(lat);
        r0 = result;
        n_checks++; if (result !== 32'hF000_F000) $display("FAIL nor_result got %h want F000F000", result); else n_pass++;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0 || zero !== 1'b0 || carry_out !== 1'b0 || overflow !== 1'b0)
                $display("FAIL hold_cycle%0d got v=%b rdy=%b r=%h want v=1 rdy=0 r=%h", i, out_valid, in_ready, result, r0); else n_pass++;
        end
        release_result();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL hold_drop got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_no_accept got in_ready %b want 1", in_ready); else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op(32'h1234_5678, 32'h1111_1111, 4'b0010);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrun_ctrl got rdy=%b v=%b want 1 0", in_ready, out_valid); else n_pass++;
        n_checks++; if ({result, zero, carry_out, overflow} !== '0) $display("FAIL midrun_outputs got %h want 0", result); else n_pass++;
        start_op(32'hFFFF_0000, 32'h0FF0_0FF0, 4'b0000);
        wait_done(lat);
        n_checks++; if (lat != W + 1) $display("FAIL after_abort_latency got %0d want %0d", lat, W + 1); else n_pass++;
        n_checks++; if (result !== 32'h0FF0_0000 || carry_out !== 1'b0 || overflow !== 1'b0)
            $display("FAIL after_abort_result got %h want 0FF00000", result); else n_pass++;
        // reset while holding a result in DONE
        #0 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1)
            $display("FAIL done_reset got v=%b r=%h rdy=%b want 0 0 1", out_valid, result, in_ready); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] corner[5], ta, tb, er;
        logic [3:0]   tc;
        logic         ez, ec, ev;
        int lat;
        corner[0] = '0; corner[1] = '1; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1;
        for (int i = 0; i < 40; i++) begin
            ta = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            tb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            tc = 4'($urandom);
            model(ta, tb, tc, er, ez, ec, ev);
            start_op(ta, tb, tc);
            n_checks++; if (in_ready !== 1'b0) $display("FAIL rnd%0d_busy got in_ready %b want 0", i, in_ready); else n_pass++;
            wait_done(lat);
            n_checks++; if (lat != W + 1) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, W + 1); else n_pass++;
            n_checks++; if (result !== er) $display("FAIL rnd%0d_result a=%h b=%h ctl=%b got %h want %h", i, ta, tb, tc, result, er); else n_pass++;
            n_checks++; if ({zero, carry_out, overflow} !== {ez, ec, ev})
                $display("FAIL rnd%0d_flags ctl=%b got %b%b%b want %b%b%b", i, tc, zero, carry_out, overflow, ez, ec, ev); else n_pass++;
            if ((i % 2) == 0) repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            release_result();
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rnd%0d_release got v=%b rdy=%b want 0 1", i, out_valid, in_ready); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ALUctl = '0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
